// File: rtl/sd_spi_sector_writer.sv
// CMD24 single-block writer for an SD card already initialised in SPI mode.
// Pulls the 512 data bytes from a 1-cycle-latency buffer and drives its own SPI pins (mode 0).
module sd_spi_sector_writer #(
    parameter int unsigned SPI_CLK_DIV        = 50,
    parameter int unsigned R1_POLL_BYTES      = 8,
    parameter int unsigned BUSY_TIMEOUT_BYTES = 65535
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] sector_no_i,
    input  logic [1:0]  sdcardtype_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  err_o,
    output logic        wreq_o,
    output logic [8:0]  waddr_o,
    input  logic [7:0]  wdata_i,
    output logic        spi_csn_o,
    output logic        spi_clk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int unsigned    DivW      = $clog2(SPI_CLK_DIV);
    localparam logic [DivW-1:0] DivLast  = DivW'(SPI_CLK_DIV - 1);
    localparam logic [15:0]    SetupLast = 16'(2 * SPI_CLK_DIV - 1);
    localparam logic [15:0]    R1Max     = 16'(R1_POLL_BYTES);
    localparam logic [15:0]    BusyMax   = 16'(BUSY_TIMEOUT_BYTES);

    typedef enum logic [3:0] {
        StIdle, StSetup, StCmd, StR1, StGap, StToken, StData,
        StCrc, StDresp, StBusy, StFin, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            xfer_q, xfer_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      err_q, err_d;
    logic            csn_q, csn_d;
    logic            wreq_q, wreq_d;
    logic [8:0]      waddr_q, waddr_d;
    logic            cap_q, cap_d;
    logic [7:0]      nxt_q, nxt_d;

    logic            byte_done;
    logic            load;
    logic [7:0]      load_val;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] a);
        case (idx)
            3'd0:    return 8'h58;
            3'd1:    return a[31:24];
            3'd2:    return a[23:16];
            3'd3:    return a[15:8];
            3'd4:    return a[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        xfer_d    = xfer_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_d     = err_q;
        csn_d     = csn_q;
        wreq_d    = 1'b0;
        waddr_d   = waddr_q;
        cap_d     = wreq_q;
        nxt_d     = nxt_q;
        byte_done = 1'b0;
        load      = 1'b0;
        load_val  = 8'hFF;

        if (cap_q) begin
            nxt_d = wdata_i;
        end

        // Byte engine: low half-bit, rise (sample), high half-bit, fall (shift or finish).
        if (xfer_q) begin
            if (div_q == DivLast) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], spi_miso_i};
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        byte_done = 1'b1;
                        xfer_d    = 1'b0;
                        mosi_d    = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    err_d  = 3'd0;
                    addr_d = (sdcardtype_i == 2'd3) ? sector_no_i : {sector_no_i[22:0], 9'd0};
                    if (sdcardtype_i == 2'd0) begin
                        err_d   = 3'd1;
                        state_d = StDone;
                    end else begin
                        csn_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    load     = 1'b1;
                    load_val = cmd_byte(3'd0, addr_q);
                    cnt_d    = '0;
                    state_d  = StCmd;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCmd: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (cnt_q == 16'd5) begin
                        cnt_d   = 16'd1;
                        state_d = StR1;
                    end else begin
                        load_val = cmd_byte(cnt_q[2:0] + 3'd1, addr_q);
                        cnt_d    = cnt_q + 16'd1;
                    end
                end
            end
            StR1: begin
                if (byte_done) begin
                    if (!rx_q[7]) begin
                        if (rx_q == 8'h00) begin
                            load    = 1'b1;
                            state_d = StGap;
                        end else begin
                            err_d   = 3'd3;
                            state_d = StFin;
                        end
                    end else if (cnt_q == R1Max) begin
                        err_d   = 3'd2;
                        state_d = StFin;
                    end else begin
                        load  = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StGap: begin
                // Prefetch byte 0 while the token goes out.
                if (byte_done) begin
                    load     = 1'b1;
                    load_val = 8'hFE;
                    wreq_d   = 1'b1;
                    waddr_d  = 9'd0;
                    state_d  = StToken;
                end
            end
            StToken: begin
                if (byte_done) begin
                    load     = 1'b1;
                    load_val = nxt_q;
                    wreq_d   = 1'b1;
                    waddr_d  = 9'd1;
                    cnt_d    = '0;
                    state_d  = StData;
                end
            end
            StData: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (cnt_q == 16'd511) begin
                        cnt_d   = '0;
                        state_d = StCrc;
                    end else begin
                        load_val = nxt_q;
                        cnt_d    = cnt_q + 16'd1;
                        if (cnt_q < 16'd510) begin
                            wreq_d  = 1'b1;
                            waddr_d = cnt_q[8:0] + 9'd2;
                        end
                    end
                end
            end
            StCrc: begin
                if (byte_done) begin
                    load  = 1'b1;
                    cnt_d = 16'd1;
                    if (cnt_q != 16'd0) begin
                        state_d = StDresp;
                    end
                end
            end
            StDresp: begin
                if (byte_done) begin
                    if (!rx_q[4]) begin
                        if (rx_q[4:0] == 5'h05) begin
                            load    = 1'b1;
                            cnt_d   = 16'd1;
                            state_d = StBusy;
                        end else begin
                            err_d   = 3'd4;
                            state_d = StFin;
                        end
                    end else if (cnt_q == 16'd8) begin
                        err_d   = 3'd4;
                        state_d = StFin;
                    end else begin
                        load  = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StBusy: begin
                if (byte_done) begin
                    if (rx_q != 8'h00) begin
                        err_d   = 3'd0;
                        state_d = StFin;
                    end else if (cnt_q == BusyMax) begin
                        err_d   = 3'd5;
                        state_d = StFin;
                    end else begin
                        load  = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StFin: begin
                // csn rises one cycle after the last fall, then 8 trailing clocks.
                if (byte_done) begin
                    state_d = StDone;
                end else if (!xfer_q && !csn_q) begin
                    csn_d = 1'b1;
                    load  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            tx_d   = load_val;
            mosi_d = load_val[7];
            bit_d  = '0;
            div_d  = '0;
            sclk_d = 1'b0;
            xfer_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            xfer_q  <= 1'b0;
            tx_q    <= 8'hFF;
            rx_q    <= 8'hFF;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= '0;
            csn_q   <= 1'b1;
            wreq_q  <= 1'b0;
            waddr_q <= '0;
            cap_q   <= 1'b0;
            nxt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            xfer_q  <= xfer_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            csn_q   <= csn_d;
            wreq_q  <= wreq_d;
            waddr_q <= waddr_d;
            cap_q   <= cap_d;
            nxt_q   <= nxt_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign wreq_o     = wreq_q;
    assign waddr_o    = waddr_q;
    assign spi_csn_o  = csn_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: doc/sd_spi_sector_writer.md
Name: sd_spi_sector_writer

Overview:
Writes one 512-byte sector to an already-initialized SD card over SPI using CMD24 (WRITE_SINGLE_BLOCK). It is the write-direction companion of the SD sector read path. Card type (for byte/block addressing) comes from the initializer's sdcardtype output. Sector data is pulled byte-by-byte from a user buffer (BRAM-style, 1-cycle read latency). The block owns its SPI pins, which are muxed with the reader at top level.

Parameters:
SPI_CLK_DIV, 50, spi_clk = clk/(2*SPI_CLK_DIV); legal range >=2
R1_POLL_BYTES, 8, max bytes polled for R1 after command
BUSY_TIMEOUT_BYTES, 65535, max bytes polled while card holds MISO low (busy)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle write request; sampled only when busy=0
sector_no  in  32  sector number, captured on accepted start
sdcardtype  in  2  0=NONE,1=SDv1,2=SDv2,3=SDHCv2
busy  out  1  high from accepted start until the done cycle (inclusive)
done  out  1  one-cycle completion pulse
err  out  3  result code, valid on done cycle and held until next start
wreq  out  1  one-cycle request for byte waddr
waddr  out  9  byte index 0..511
wdata  in  8  buffer data, valid exactly 1 clk after wreq
spi_csn  out  1  chip select, active low
spi_clk  out  1  SPI clock, mode 0, idle low
spi_mosi  out  1  master out; idle high
spi_miso  in  1  master in

Behaviour:
- Reset (async): busy=0, done=0, err=0, wreq=0, waddr=0, spi_csn=1, spi_clk=0, spi_mosi=1, FSM=IDLE. Reset mid-transfer aborts: no done pulse; pins return to reset values immediately.
- SPI byte engine: MSB first; mosi changes on falling edge (first bit set before first rise); miso sampled on rising edge; one bit = 2*SPI_CLK_DIV clks; bytes back-to-back, no gap; "poll byte" = transmit 0xFF, capture received byte.
- Address: SDHCv2 -> sector_no; SDv1/SDv2 -> sector_no<<9 (low 32 bits kept).
- start with sdcardtype=NONE: no SPI activity; done next cycle, err=1.
- start while busy=1: ignored.
- FSM (all bytes with csn=0 unless stated):
  IDLE -> CMD on accepted start (csn falls 1 bit-time before first byte).
  CMD: send 0x58, addr[31:24], [23:16], [15:8], [7:0], 0xFF.
  R1: poll until received byte bit7=0; byte==0x00 -> GAP; nonzero -> FIN err=3; R1_POLL_BYTES polls without bit7=0 -> FIN err=2.
  GAP: one 0xFF byte. TOKEN: send 0xFE.
  DATA: send 512 bytes from buffer, index 0 first. For byte n, wreq pulses with waddr=n >=2 clks before that byte's first bit; wdata captured 1 clk after wreq. Each index requested exactly once, ascending.
  CRC: send 0xFF, 0xFF.
  DRESP: poll until bit4=0 (max 8 polls, else err=4); (byte & 0x1F)==0x05 -> BUSY; otherwise FIN err=4.
  BUSY: poll while received byte==0x00; first non-zero byte -> FIN err=0; BUSY_TIMEOUT_BYTES polls -> FIN err=5.
  FIN: csn=1, then send 8 clocks with mosi=1 (one 0xFF byte), then DONE.
  DONE: done=1 for one cycle, busy drops with it, back to IDLE.
- err codes: 0 ok, 1 no card, 2 R1 timeout, 3 R1 error, 4 data rejected/no data response, 5 busy timeout.
- spi_clk is always low when csn changes.

Test Plan:
- SDHCv2, sector_no=5, card model R1=0x00, DRESP=0xE5, 3 busy bytes 0x00 then 0xFF -> MOSI 58 00 00 00 05 FF, FE, buffer bytes 0..511, FF FF; waddr 0..511 once each in order; done with err=0, busy covers whole transfer.
- SDv2, sector_no=3 -> command address bytes 00 00 06 00; SDv1, sector_no=0x00800001 -> address 00 00 02 00 (wrap to 32 bits).
- Card never answers (MISO=1 constantly) -> after 8 R1 poll bytes, csn high, done with err=2; no wreq ever pulses.
- R1=0x04 -> err=3. DRESP=0xEB (CRC error) -> err=4. Busy held low forever with BUSY_TIMEOUT_BYTES=16 -> err=5 after 16 poll bytes.
- sdcardtype=NONE, start -> done 1 clk later, err=1, csn stays 1. Second start during transfer -> ignored, exactly one done.
- Assert rst_n low mid-DATA (byte 100) -> csn=1, spi_clk=0, mosi=1, busy=0 immediately; no done; new start afterwards completes normally with err=0.
